// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access.
// Define ARB_RR_EN for round-robin contention; fixed D priority otherwise.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        grant_d,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            terr_q, terr_d;
    logic            d_req;
    logic            favour_d;
`ifdef ARB_RR_EN
    logic            last_d_q, last_d_d;
`endif

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdog_d  = wdog_q;
        terr_d  = terr_q;
        d_req   = d_read | d_write;
`ifdef ARB_RR_EN
        last_d_d = last_d_q;
        favour_d = ~last_d_q;
`else
        favour_d = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (d_req && (!i_read || favour_d)) begin
                    state_d = D_BUSY;
                    rd_d    = d_read & ~d_write;
                    wr_d    = d_write;
                    be_d    = d_byte_enable;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wdog_d  = '0;
`ifdef ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_read) begin
                    state_d = I_BUSY;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    be_d    = 4'hF;
                    addr_d  = {i_addr[31:2], 2'b00};
                    wdata_d = '0;
                    wdog_d  = '0;
`ifdef ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    // Counter saturates; the error flag stays sticky.
                    if (wdog_q != WD_MAX) wdog_d = wdog_q + 1'b1;
                    if (wdog_q == WD_LAST) terr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
`ifdef ARB_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
`ifdef ARB_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    assign i_resp          = (state_q == I_BUSY) & mem_resp;
    assign d_resp          = (state_q == D_BUSY) & mem_resp;
    assign i_rdata         = (state_q == I_BUSY) ? mem_rdata : '0;
    assign d_rdata         = (state_q == D_BUSY) ? mem_rdata : '0;
    assign grant_d         = (state_q == D_BUSY);
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign timeout_err     = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Honours ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        grant_d;
    logic        timeout_err;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .grant_d(grant_d), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, what it asked for, how long it waited.
    int          m_owner = 0;
    logic        m_rd = 0;
    logic        m_wr = 0;
    logic [3:0]  m_be = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    int          m_busy = 0;
    logic        m_err = 0;
    logic        m_last_d = 0;

    function automatic bit pick_d(input logic ir, input logic dr,
                                  input logic dw, input logic last_d);
`ifdef ARB_RR_EN
        return (dr | dw) && (!ir || !last_d);
`else
        return (dr | dw) && (ir | !ir) && (last_d | !last_d);
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= 0; m_rd <= 0; m_wr <= 0; m_be <= 0;
            m_addr <= 0; m_wdata <= 0; m_busy <= 0; m_err <= 0;
            m_last_d <= 0;
        end else if (m_owner == 0) begin
            if (pick_d(i_read, d_read, d_write, m_last_d)) begin
                m_owner <= 2; m_wr <= d_write; m_rd <= !d_write;
                m_be <= d_byte_enable; m_addr <= d_addr;
                m_wdata <= d_wdata; m_busy <= 0; m_last_d <= 1;
            end else if (i_read) begin
                m_owner <= 1; m_wr <= 0; m_rd <= 1; m_be <= 4'hF;
                m_addr <= i_addr & ~32'h3; m_wdata <= 0;
                m_busy <= 0; m_last_d <= 0;
            end
        end else if (mem_resp) begin
            m_owner <= 0; m_rd <= 0; m_wr <= 0;
        end else begin
            m_busy <= m_busy + 1;
            if (m_busy + 1 >= TO) m_err <= 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m.mem_read", 32'(mem_read), 32'(m_rd));
            chk("m.mem_write", 32'(mem_write), 32'(m_wr));
            chk("m.mem_be", 32'(mem_byte_enable), 32'(m_be));
            chk("m.mem_address", mem_address, m_addr);
            chk("m.mem_wdata", mem_wdata, m_wdata);
            chk("m.i_resp", 32'(i_resp), 32'(m_owner == 1 && mem_resp));
            chk("m.d_resp", 32'(d_resp), 32'(m_owner == 2 && mem_resp));
            chk("m.i_rdata", i_rdata, (m_owner == 1) ? mem_rdata : 32'h0);
            chk("m.d_rdata", d_rdata, (m_owner == 2) ? mem_rdata : 32'h0);
            chk("m.grant_d", 32'(grant_d), 32'(m_owner == 2));
            chk("m.timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ord;
    logic [3:0] exp_ord;
    bit got;

    initial begin
        rst = 1; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
        d_byte_enable = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_resp = 0;
        #2 rst = 0;
        #1 cmp_on = 1;
        i_read = 1; i_addr = 32'h62;
        tick(); tick();
        @(negedge clk);
        chk("rst.mem_read", 32'(mem_read), 0);
        chk("rst.mem_address", mem_address, 0);
        chk("rst.i_resp", 32'(i_resp), 0);
        chk("rst.timeout_err", 32'(timeout_err), 0);
        tick(); rst = 1;
        @(negedge clk);
        chk("rel.no_grant_yet", 32'(mem_read), 0);
        tick();
        @(negedge clk);
        chk("fetch.mem_read", 32'(mem_read), 1);
        chk("fetch.mem_address", mem_address, 32'h60);
        chk("fetch.be", 32'(mem_byte_enable), 32'hF);
        tick(); tick();
        mem_resp = 1; mem_rdata = 32'h13;
        @(negedge clk);
        chk("fetch.i_resp", 32'(i_resp), 1);
        chk("fetch.i_rdata", i_rdata, 32'h13);
        chk("fetch.d_resp", 32'(d_resp), 0);
        tick(); mem_resp = 0; mem_rdata = 0; i_read = 0;
        @(negedge clk);
        chk("fetch.drop", 32'(mem_read), 0);

        i_read = 1; i_addr = 32'h84; d_write = 1; d_addr = 32'h1000;
        d_wdata = 32'hDEADBEEF; d_byte_enable = 4'h3;
        tick();
        @(negedge clk);
        chk("cont.mem_write", 32'(mem_write), 1);
        chk("cont.mem_read", 32'(mem_read), 0);
        chk("cont.be", 32'(mem_byte_enable), 32'h3);
        chk("cont.grant_d", 32'(grant_d), 1);
        chk("cont.wdata", mem_wdata, 32'hDEADBEEF);
        tick(); mem_resp = 1;
        @(negedge clk);
        chk("cont.d_resp", 32'(d_resp), 1);
        tick(); mem_resp = 0; d_write = 0;
        @(negedge clk);
        chk("cont.bubble", 32'(mem_read | mem_write | grant_d), 0);
        tick();
        @(negedge clk);
        chk("cont.i_grant", 32'(mem_read), 1);
        chk("cont.i_addr", mem_address, 32'h84);
        tick(); mem_resp = 1; mem_rdata = 32'h55;
        tick(); mem_resp = 0; mem_rdata = 0; i_read = 0;

        i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
        d_byte_enable = 4'hF;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int w = 0; w < 10 && !got; w++) begin
                tick();
                @(negedge clk);
                if (mem_read | mem_write) got = 1;
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL fair.grant%0d: got none expected a grant", k);
            end
            ord[k] = grant_d;
            tick(); mem_resp = 1;
            tick(); mem_resp = 0;
        end
`ifdef ARB_RR_EN
        exp_ord = 4'b0101;
`else
        exp_ord = 4'b1111;
`endif
        chk("fair.order", 32'(ord), 32'(exp_ord));
        i_read = 0; d_read = 0;

        d_read = 1; d_addr = 32'h2000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 20) begin
                mem_resp = 1; mem_rdata = 32'hCAFE0001;
            end
            @(negedge clk);
            if (c == 1) chk("wd.grant_d", 32'(grant_d), 1);
            if (c == 16) chk("wd.err_c16", 32'(timeout_err), 0);
            if (c == 17) begin
                chk("wd.err_c17", 32'(timeout_err), 1);
                chk("wd.mem_read", 32'(mem_read), 1);
            end
            if (c == 20) begin
                chk("wd.d_resp", 32'(d_resp), 1);
                chk("wd.d_rdata", d_rdata, 32'hCAFE0001);
                chk("wd.err_c20", 32'(timeout_err), 1);
            end
        end
        tick(); mem_resp = 0; mem_rdata = 0; d_read = 0;
        @(negedge clk);
        chk("wd.sticky", 32'(timeout_err), 1);

        i_read = 1; i_addr = 32'h40;
        tick();
        @(negedge clk);
        chk("mrst.busy", 32'(mem_read), 1);
        #2 rst = 0;
        #1 chk("mrst.mem_read", 32'(mem_read), 0);
        mem_resp = 1;
        #1 chk("mrst.i_resp", 32'(i_resp), 0);
        tick(); rst = 1; i_read = 0;
        @(negedge clk);
        chk("mrst.idle_resp", 32'(i_resp), 0);
        chk("mrst.err_clr", 32'(timeout_err), 0);
        tick(); mem_resp = 0;
        tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
